mc_rq_arbiter: RTL

- Shares one MC port among NUM_CORES phold simulation cores inside the personality.
- Round-robin arbitrates core memory requests onto the MC request interface.
- Tags each request's rtnctl with the issuing core ID, and steers MC responses back to that core by the tag.
- Sits between the phold core array and the cae_pers MC port.

---
 rtl/mc_rq_arbiter_if.sv | 73 +++++++
 rtl/mc_rq_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mc_rq_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mc_rq_arbiter_if : core-array <-> MC port bundle for mc_rq_arbiter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mc_rq_arbiter_if #(
  parameter int NUM_CORES    = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int ID_W         = 2
);
  // Core request side (flattened, core i occupies slice i)
  logic [NUM_CORES-1:0]                       core_rq_vld;
  logic [3*NUM_CORES-1:0]                     core_rq_cmd;
  logic [4*NUM_CORES-1:0]                     core_rq_scmd;
  logic [2*NUM_CORES-1:0]                     core_rq_size;
  logic [48*NUM_CORES-1:0]                    core_rq_vadr;
  logic [64*NUM_CORES-1:0]                    core_rq_data;
  logic [(RTNCTL_WIDTH-ID_W)*NUM_CORES-1:0]   core_rq_rtnctl;
  logic [NUM_CORES-1:0]                       core_rq_gnt;

  logic                                       mc_rq_vld;
  logic [2:0]                                 mc_rq_cmd;
  logic [3:0]                                 mc_rq_scmd;
  logic [1:0]                                 mc_rq_size;
  logic [47:0]                                mc_rq_vadr;
  logic [63:0]                                mc_rq_data;
  logic [RTNCTL_WIDTH-1:0]                    mc_rq_rtnctl;
  logic                                       mc_rq_stall;

  logic                                       mc_rs_vld;
  logic [2:0]                                 mc_rs_cmd;
  logic [3:0]                                 mc_rs_scmd;
  logic [63:0]                                mc_rs_data;
  logic [RTNCTL_WIDTH-1:0]                    mc_rs_rtnctl;
  logic                                       mc_rs_stall;

  logic [NUM_CORES-1:0]                       core_rs_vld;
  logic [2:0]                                 core_rs_cmd;
  logic [3:0]                                 core_rs_scmd;
  logic [63:0]                                core_rs_data;
  logic [RTNCTL_WIDTH-ID_W-1:0]               core_rs_rtnctl;
  logic [NUM_CORES-1:0]                       core_rs_stall;

  // master: the arbiter's view; slave: the surrounding core array / MC port
  modport master (
    input  core_rq_vld, core_rq_cmd, core_rq_scmd, core_rq_size,
           core_rq_vadr, core_rq_data, core_rq_rtnctl,
    output core_rq_gnt,
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size,
           mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    input  mc_rq_stall,
    input  mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    output mc_rs_stall,
    output core_rs_vld, core_rs_cmd, core_rs_scmd, core_rs_data, core_rs_rtnctl,
    input  core_rs_stall
  );

  modport slave (
    output core_rq_vld, core_rq_cmd, core_rq_scmd, core_rq_size,
           core_rq_vadr, core_rq_data, core_rq_rtnctl,
    input  core_rq_gnt,
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_size,
           mc_rq_vadr, mc_rq_data, mc_rq_rtnctl,
    output mc_rq_stall,
    output mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl,
    input  mc_rs_stall,
    input  core_rs_vld, core_rs_cmd, core_rs_scmd, core_rs_data, core_rs_rtnctl,
    output core_rs_stall
  );
endinterface

`default_nettype wire

// File: rtl/mc_rq_arbiter.sv
// +----------------------------------------------------------------------+
// | mc_rq_arbiter : round-robin MC request arbiter with ID-tagged returns |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mc_rq_arbiter #(
  parameter int NUM_CORES    = 4,
  parameter int RTNCTL_WIDTH = 32,
  parameter int ID_W         = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_rq_arbiter_if.master bus_io
);

  localparam int              TAG_W = RTNCTL_WIDTH - ID_W;
  localparam logic [ID_W:0]   NC    = (ID_W+1)'(NUM_CORES);

  // Request output register
  logic                    rq_vld_q,    rq_vld_d;
  logic [2:0]              rq_cmd_q,    rq_cmd_d;
  logic [3:0]              rq_scmd_q,   rq_scmd_d;
  logic [1:0]              rq_size_q,   rq_size_d;
  logic [47:0]             rq_vadr_q,   rq_vadr_d;
  logic [63:0]             rq_data_q,   rq_data_d;
  logic [RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
  logic [ID_W-1:0]         ptr_q,       ptr_d;

  // Response stage
  logic [NUM_CORES-1:0]    rs_vld_q,    rs_vld_d;
  logic [2:0]              rs_cmd_q,    rs_cmd_d;
  logic [3:0]              rs_scmd_q,   rs_scmd_d;
  logic [63:0]             rs_data_q,   rs_data_d;
  logic [TAG_W-1:0]        rs_tag_q,    rs_tag_d;
  logic                    rs_stall_q,  rs_stall_d;

  logic                    arb_found;
  logic [ID_W-1:0]         arb_win;
  logic [ID_W:0]           arb_cand;
  logic                    rq_load;
  logic [NUM_CORES-1:0]    rq_gnt;
  logic [ID_W-1:0]         rs_id;

  // Rotating priority search starting at ptr_q; first valid requester wins.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (arb_cand >= NC) begin
        arb_cand = arb_cand - NC;
      end
      if (!arb_found && bus_io.core_rq_vld[arb_cand[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    int wi;
    wi          = int'(arb_win);
    rq_load     = !rq_vld_q || !bus_io.mc_rq_stall;
    rq_vld_d    = rq_vld_q;
    rq_cmd_d    = rq_cmd_q;
    rq_scmd_d   = rq_scmd_q;
    rq_size_d   = rq_size_q;
    rq_vadr_d   = rq_vadr_q;
    rq_data_d   = rq_data_q;
    rq_rtnctl_d = rq_rtnctl_q;
    ptr_d       = ptr_q;
    rq_gnt      = '0;
    if (rq_load) begin
      rq_vld_d = arb_found;
      if (arb_found) begin
        rq_gnt[arb_win] = 1'b1;
        rq_cmd_d    = bus_io.core_rq_cmd [wi*3  +: 3];
        rq_scmd_d   = bus_io.core_rq_scmd[wi*4  +: 4];
        rq_size_d   = bus_io.core_rq_size[wi*2  +: 2];
        rq_vadr_d   = bus_io.core_rq_vadr[wi*48 +: 48];
        rq_data_d   = bus_io.core_rq_data[wi*64 +: 64];
        rq_rtnctl_d = {arb_win, bus_io.core_rq_rtnctl[wi*TAG_W +: TAG_W]};
        ptr_d       = ({1'b0, arb_win} == NC - 1'b1) ? '0 : arb_win + 1'b1;
      end
    end
  end

  // Out-of-range IDs (possible when NUM_CORES is not a power of two) are dropped.
  always_comb begin
    rs_id      = bus_io.mc_rs_rtnctl[RTNCTL_WIDTH-1 -: ID_W];
    rs_vld_d   = '0;
    rs_cmd_d   = rs_cmd_q;
    rs_scmd_d  = rs_scmd_q;
    rs_data_d  = rs_data_q;
    rs_tag_d   = rs_tag_q;
    rs_stall_d = |bus_io.core_rs_stall;
    if (bus_io.mc_rs_vld) begin
      if ({1'b0, rs_id} < NC) begin
        rs_vld_d[rs_id] = 1'b1;
      end
      rs_cmd_d  = bus_io.mc_rs_cmd;
      rs_scmd_d = bus_io.mc_rs_scmd;
      rs_data_d = bus_io.mc_rs_data;
      rs_tag_d  = bus_io.mc_rs_rtnctl[TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_vld_q    <= 1'b0;
      rq_cmd_q    <= '0;
      rq_scmd_q   <= '0;
      rq_size_q   <= '0;
      rq_vadr_q   <= '0;
      rq_data_q   <= '0;
      rq_rtnctl_q <= '0;
      ptr_q       <= '0;
      rs_vld_q    <= '0;
      rs_cmd_q    <= '0;
      rs_scmd_q   <= '0;
      rs_data_q   <= '0;
      rs_tag_q    <= '0;
      rs_stall_q  <= 1'b0;
    end else begin
      rq_vld_q    <= rq_vld_d;
      rq_cmd_q    <= rq_cmd_d;
      rq_scmd_q   <= rq_scmd_d;
      rq_size_q   <= rq_size_d;
      rq_vadr_q   <= rq_vadr_d;
      rq_data_q   <= rq_data_d;
      rq_rtnctl_q <= rq_rtnctl_d;
      ptr_q       <= ptr_d;
      rs_vld_q    <= rs_vld_d;
      rs_cmd_q    <= rs_cmd_d;
      rs_scmd_q   <= rs_scmd_d;
      rs_data_q   <= rs_data_d;
      rs_tag_q    <= rs_tag_d;
      rs_stall_q  <= rs_stall_d;
    end
  end

  // Grant is combinational; gate it so every output is 0 while reset is held.
  assign bus_io.core_rq_gnt    = rq_gnt & {NUM_CORES{rst_n}};
  assign bus_io.mc_rq_vld      = rq_vld_q;
  assign bus_io.mc_rq_cmd      = rq_cmd_q;
  assign bus_io.mc_rq_scmd     = rq_scmd_q;
  assign bus_io.mc_rq_size     = rq_size_q;
  assign bus_io.mc_rq_vadr     = rq_vadr_q;
  assign bus_io.mc_rq_data     = rq_data_q;
  assign bus_io.mc_rq_rtnctl   = rq_rtnctl_q;
  assign bus_io.mc_rs_stall    = rs_stall_q;
  assign bus_io.core_rs_vld    = rs_vld_q;
  assign bus_io.core_rs_cmd    = rs_cmd_q;
  assign bus_io.core_rs_scmd   = rs_scmd_q;
  assign bus_io.core_rs_data   = rs_data_q;
  assign bus_io.core_rs_rtnctl = rs_tag_q;

endmodule

`default_nettype wire
